// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared encodings for the HiLo multiply/divide sequencer and the controllers
// that issue MULT/MULTU/DIV/DIVU to it.
package hilo_muldiv_sequencer_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIX   = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Operation encodings, also decoded by the datapath and ALU controllers.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  // Divide ops have the upper op bit set.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops (MULT, DIV) have the lower op bit clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_if.sv
// Request/result bundle between the datapath controller (master) and the
// multiply/divide sequencer (slave).
interface hilo_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic                 hilo_en;
  logic [2*WIDTH-1:0]   hilo_write;

  modport master (
    output start, op, a, b,
    input  busy, done, hilo_en, hilo_write
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hilo_en, hilo_write
  );
endinterface

// File: rtl/hilo_muldiv_sequencer_neg_abs.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore result signs after the unsigned iteration loop.
module neg_abs #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  // Negate when requested, otherwise pass the value through.
  assign o_val = i_neg ? ((~i_val) + WIDTH'(1'b1)) : i_val;

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative 32-step shift-add multiplier / restoring divider that owns the
// HiLo write port. Signed ops run on magnitudes and fix the signs afterwards,
// so one unsigned loop serves all four operations.
module hilo_muldiv_sequencer
  import hilo_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  hilo_muldiv_sequencer_if.slave   s_bus
);

  localparam int CW = $clog2(WIDTH);

  // State and shared datapath registers. For both op classes r_acc_lo starts
  // with |A| and r_opnd holds |B|:
  //   multiply: r_acc_lo is the multiplier shifting out, {r_acc_hi, r_acc_lo}
  //             collects the product;
  //   divide:   r_acc_hi is the remainder, r_acc_lo the dividend/quotient.
  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opnd;

  logic             w_accept;
  logic             w_signed_op;
  logic             w_div_op;
  logic             w_div_by_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // ---------------------------------------------------------------------------
  // Request decode and operand magnitudes
  // ---------------------------------------------------------------------------
  assign w_accept      = (r_state == IDLE) && s_bus.start;
  assign w_signed_op   = op_is_signed(s_bus.op);
  assign w_div_op      = op_is_div(s_bus.op);
  assign w_div_by_zero = w_div_op && (s_bus.b == '0);

  neg_abs #(.WIDTH(WIDTH)) u_abs_a (
    .i_neg (w_signed_op & s_bus.a[WIDTH-1]),
    .i_val (s_bus.a),
    .o_val (w_a_mag)
  );

  neg_abs #(.WIDTH(WIDTH)) u_abs_b (
    .i_neg (w_signed_op & s_bus.b[WIDTH-1]),
    .i_val (s_bus.b),
    .o_val (w_b_mag)
  );

  // ---------------------------------------------------------------------------
  // One multiply step: conditional add with carry, then shift right by one
  // ---------------------------------------------------------------------------
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // One restoring-divide step. The shifted remainder is below twice the
  // divisor, so a WIDTH+1-bit trial difference has a reliable sign bit.
  // ---------------------------------------------------------------------------
  assign w_rem_sh = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_opnd};
  assign w_div_hi = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_div_lo = {r_acc_lo[WIDTH-2:0], ~w_trial[WIDTH]};

  // ---------------------------------------------------------------------------
  // Sign restoration applied in FIX
  // ---------------------------------------------------------------------------
  neg_abs #(.WIDTH(2*WIDTH)) u_fix_prod (
    .i_neg (r_neg_q),
    .i_val ({r_acc_hi, r_acc_lo}),
    .o_val (w_prod_fix)
  );

  neg_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .i_neg (r_neg_q),
    .i_val (r_acc_lo),
    .o_val (w_quo_fix)
  );

  neg_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .i_neg (r_neg_r),
    .i_val (r_acc_hi),
    .o_val (w_rem_fix)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register; reset aborts any op in flight.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state selection; divide by zero skips the loop and writes directly.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (s_bus.start) w_next_state = w_div_by_zero ? WRITE : RUN;
      RUN:   if (r_cnt == '0) w_next_state = FIX;
      FIX:   w_next_state = WRITE;
      WRITE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Stall request, commit strobe and result bus; result bus is zero when idle.
  always_comb begin
    s_bus.busy       = 1'b0;
    s_bus.done       = 1'b0;
    s_bus.hilo_en    = 1'b0;
    s_bus.hilo_write = '0;
    unique case (r_state)
      IDLE:  s_bus.busy = s_bus.start;
      RUN:   s_bus.busy = 1'b1;
      FIX:   s_bus.busy = 1'b1;
      WRITE: begin
        s_bus.done       = 1'b1;
        s_bus.hilo_en    = 1'b1;
        s_bus.hilo_write = {r_acc_hi, r_acc_lo};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: capture on accept, iterate in RUN, restore signs in FIX
  // ---------------------------------------------------------------------------

  // Shared accumulator/operand registers with per-state muxed updates.
  // NOTE: these are plain flops, not a memory array, so they are reset to
  // give a defined HiLo image and counter after every reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_div <= w_div_op;
            r_cnt    <= CW'(WIDTH - 1);
            if (w_div_by_zero) begin
              r_neg_q  <= 1'b0;
              r_neg_r  <= 1'b0;
              r_acc_hi <= s_bus.a;
              r_acc_lo <= '1;
              r_opnd   <= '0;
            end else begin
              r_neg_q  <= w_signed_op & (s_bus.a[WIDTH-1] ^ s_bus.b[WIDTH-1]);
              r_neg_r  <= w_signed_op & s_bus.a[WIDTH-1];
              r_acc_hi <= '0;
              r_acc_lo <= w_a_mag;
              r_opnd   <= w_b_mag;
            end
          end
        end
        RUN: begin
          if (r_is_div) begin
            r_acc_hi <= w_div_hi;
            r_acc_lo <= w_div_lo;
          end else begin
            r_acc_hi <= w_mul_hi;
            r_acc_lo <= w_mul_lo;
          end
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        FIX: begin
          if (r_is_div) begin
            r_acc_hi <= w_rem_fix;
            r_acc_lo <= w_quo_fix;
          end else begin
            {r_acc_hi, r_acc_lo} <= w_prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Randomised and directed bench for the HiLo multiply/divide sequencer.
// Expected results come from 64-bit integer arithmetic, expected timing from
// the cycle numbering of the op (WRITE at cycle 34, or cycle 1 on divide by 0).
module tb_hilo_muldiv_sequencer;
  import hilo_muldiv_sequencer_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  hilo_muldiv_sequencer_if #(.WIDTH(W)) bus ();

  hilo_muldiv_sequencer #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference {Hi, Lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_hilo(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MULT) begin
      res = sa * sb;
    end else if (op == OP_MULTU) begin
      res = {32'd0, a} * {32'd0, b};
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (op == OP_DIV) begin
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  // Issue one op and watch 40 cycles: result, Done timing, Done count, Busy
  // profile and an all-zero result bus outside the commit cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit restart);
    logic [63:0] exp;
    logic [63:0] got;
    int          exp_cyc;
    int          done_cyc;
    int          done_cnt;
    int          busy_err;
    int          bus_err;
    exp      = ref_hilo(op, a, b);
    exp_cyc  = (op[1] && b == 32'd0) ? 1 : 34;
    done_cyc = -1;
    done_cnt = 0;
    busy_err = 0;
    bus_err  = 0;
    got      = '0;

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    #1;
    if (bus.busy !== 1'b1) busy_err++;

    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (restart && k == 5) begin
        bus.start = 1'b1;
        bus.op    = op ^ 2'b01;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      if (bus.busy !== (k < exp_cyc)) busy_err++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (bus.hilo_en !== 1'b1) bus_err++;
        if (done_cyc < 0) begin
          done_cyc = k;
          got      = bus.hilo_write;
        end
      end else if (bus.hilo_en !== 1'b0 || bus.hilo_write !== 64'd0) begin
        bus_err++;
      end
    end

    check({tag, " result"}, got, exp);
    check({tag, " done cycle"}, 64'(done_cyc), 64'(exp_cyc));
    check({tag, " done count"}, 64'(done_cnt), 64'd1);
    check({tag, " busy profile"}, 64'(busy_err), 64'd0);
    check({tag, " bus idle"}, 64'(bus_err), 64'd0);
  endtask

  // Start a DIV, reset it at cycle 10 and confirm no commit ever follows.
  task automatic abort_div();
    int bad;
    bad = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = $urandom;
    bus.b     = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    check("abort busy before rst", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort busy after rst", 64'(bus.busy), 64'd0);
    check("abort hilo_en after rst", 64'(bus.hilo_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (bus.hilo_en !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    check("abort no commit", 64'(bad), 64'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hilo_en", 64'(bus.hilo_en), 64'd0);
    check("reset hilo_write", bus.hilo_write, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("idle busy", 64'(bus.busy), 64'd0);

    // Directed cases, including the boundary conditions.
    run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 1'b0);
    run_op("divu by 0", OP_DIVU, 32'd100, 32'd0, 1'b0);
    run_op("div neg by 0", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
    run_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("divu max/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("mult restart", OP_MULT, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

    abort_div();
    run_op("after abort", OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);

    // Randomised ops; divisors are sometimes zero or small.
    for (int i = 0; i < 24; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        2:       r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, (i % 8) == 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
